zap_wb_arbiter: RTL and testbench



---
 rtl/zap_wb_arbiter_pkg.sv | 30 +++
 rtl/zap_wb_arb_timeout.sv | 34 +++
 rtl/zap_wb_arbiter.sv | 134 +++++++++++++
 tb/tb_zap_wb_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zap_wb_arbiter_pkg.sv
// Shared types and constants for the Wishbone arbiter: grant states, CTI codes and the
// arbitration decision used by the top.
package zap_wb_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StGnt0 = 2'd1,
    StGnt1 = 2'd2
  } arb_state_e;

  localparam logic [2:0] CtiClassic = 3'b000;
  localparam logic [2:0] CtiBurst   = 3'b010;
  localparam logic [2:0] CtiEob     = 3'b111;

  // Mode 0: on a tie the master that was not served last wins. Mode 1: master 1 wins ties.
  function automatic arb_state_e arb_pick(input int unsigned mode, input logic req0,
                                          input logic req1, input logic last);
    arb_state_e pick;
    pick = StIdle;
    if (req0 && req1) begin
      pick = (mode == 1 || last == 1'b0) ? StGnt1 : StGnt0;
    end else if (req0) begin
      pick = StGnt0;
    end else if (req1) begin
      pick = StGnt1;
    end
    return pick;
  endfunction

endpackage

// File: rtl/zap_wb_arb_timeout.sv
// Stall watchdog for the granted master: counts unacknowledged strobe cycles and flags
// expiry on the stall cycle that reaches TIMEOUT_CYCLES.
module zap_wb_arb_timeout #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1024
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_stall,
  input  logic i_clear,
  output logic o_expired
);

  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_stall) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_expired = i_stall && (cnt_q == TIMEOUT_CYCLES - 32'd1);

endmodule

// File: rtl/zap_wb_arbiter.sv
// Two-master Wishbone arbiter (instruction side m0, data side m1) onto one system bus.
// Define ZAP_WB_ARB_TIMEOUT_EN to add a stall timeout that errors and releases the bus.
module zap_wb_arbiter
  import zap_wb_arbiter_pkg::*;
#(
  parameter int unsigned ARB_MODE       = 0,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1024
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_m0_cyc,
  input  logic        i_m0_stb,
  input  logic        i_m0_wen,
  input  logic [31:0] i_m0_adr,
  input  logic [31:0] i_m0_dat,
  input  logic [3:0]  i_m0_sel,
  input  logic [2:0]  i_m0_cti,
  output logic        o_m0_ack,
  output logic        o_m0_err,
  input  logic        i_m1_cyc,
  input  logic        i_m1_stb,
  input  logic        i_m1_wen,
  input  logic [31:0] i_m1_adr,
  input  logic [31:0] i_m1_dat,
  input  logic [3:0]  i_m1_sel,
  input  logic [2:0]  i_m1_cti,
  output logic        o_m1_ack,
  output logic        o_m1_err,
  output logic [31:0] o_m_dat,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_wen,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic [2:0]  o_wb_cti,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_ack,
  output logic [1:0]  o_grant
);

  arb_state_e state_q, state_d, arb_next;
  logic       last_q, last_d;
  logic       bus_cyc, bus_stb;
  logic       tmo_err;

  always_comb begin
    arb_next = arb_pick(ARB_MODE, i_m0_cyc, i_m1_cyc, last_q);
    state_d  = state_q;
    unique case (state_q)
      StIdle:  state_d = arb_next;
      StGnt0:  if (!i_m0_cyc) state_d = arb_next;
      StGnt1:  if (!i_m1_cyc) state_d = arb_next;
      default: state_d = StIdle;
    endcase
    if (tmo_err) begin
      state_d = StIdle;
    end
    last_d = last_q;
    if (state_d == StGnt0) begin
      last_d = 1'b0;
    end else if (state_d == StGnt1) begin
      last_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Muxing on the registered state keeps a dropped cyc visible as a one-cycle gap.
  always_comb begin
    bus_cyc  = 1'b0;
    bus_stb  = 1'b0;
    o_wb_wen = 1'b0;
    o_wb_adr = '0;
    o_wb_dat = '0;
    o_wb_sel = '0;
    o_wb_cti = CtiClassic;
    unique case (state_q)
      StGnt0: begin
        bus_cyc  = i_m0_cyc;
        bus_stb  = i_m0_stb;
        o_wb_wen = i_m0_wen;
        o_wb_adr = i_m0_adr;
        o_wb_dat = i_m0_dat;
        o_wb_sel = i_m0_sel;
        o_wb_cti = i_m0_cti;
      end
      StGnt1: begin
        bus_cyc  = i_m1_cyc;
        bus_stb  = i_m1_stb;
        o_wb_wen = i_m1_wen;
        o_wb_adr = i_m1_adr;
        o_wb_dat = i_m1_dat;
        o_wb_sel = i_m1_sel;
        o_wb_cti = i_m1_cti;
      end
      default: ;
    endcase
  end

  assign o_wb_cyc = bus_cyc && !tmo_err;
  assign o_wb_stb = bus_stb && !tmo_err;
  assign o_grant  = {state_q == StGnt1, state_q == StGnt0};
  assign o_m0_ack = i_wb_ack && (state_q == StGnt0);
  assign o_m1_ack = i_wb_ack && (state_q == StGnt1);
  assign o_m_dat  = i_wb_dat;

`ifdef ZAP_WB_ARB_TIMEOUT_EN
  zap_wb_arb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_stall  ((state_q != StIdle) && bus_stb && !i_wb_ack),
    .i_clear  (i_wb_ack || (state_d != state_q)),
    .o_expired(tmo_err)
  );
  assign o_m0_err = tmo_err && (state_q == StGnt0);
  assign o_m1_err = tmo_err && (state_q == StGnt1);
`else
  assign tmo_err  = 1'b0;
  assign o_m0_err = 1'b0;
  assign o_m1_err = 1'b0;
`endif

endmodule

// File: tb/tb_zap_wb_arbiter.sv
// Bench for zap_wb_arbiter: a round-robin and a fixed-priority instance share stimulus and
// are checked every cycle against an owner/last-served model, plus directed scenario checks.
module tb_zap_wb_arbiter;

`ifdef ZAP_WB_ARB_TIMEOUT_EN
  localparam bit TmoEn = 1'b1;
`else
  localparam bit TmoEn = 1'b0;
`endif
  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m_cyc [2];
  logic        m_stb [2];
  logic        m_wen [2];
  logic [31:0] m_adr [2];
  logic [31:0] m_dat [2];
  logic [3:0]  m_sel [2];
  logic [2:0]  m_cti [2];
  logic [31:0] wb_rdat;
  logic        wb_ack;

  // Index 0: ARB_MODE 0 instance, index 1: ARB_MODE 1 instance
  logic        ack0 [2];
  logic        ack1 [2];
  logic        err0 [2];
  logic        err1 [2];
  logic [31:0] mdat [2];
  logic        wcyc [2];
  logic        wstb [2];
  logic        wwen [2];
  logic [31:0] wadr [2];
  logic [31:0] wdat [2];
  logic [3:0]  wsel [2];
  logic [2:0]  wcti [2];
  logic [1:0]  grant [2];

  int n_assert = 0;
  int n_fail   = 0;

  // Model: who owns the bus (-1 none), who was served last, and the stall count
  int owner [2];
  int last  [2];
  int cnt   [2];

  for (genvar k = 0; k < 2; k++) begin : g_dut
    zap_wb_arbiter #(
      .ARB_MODE      (k),
      .TIMEOUT_CYCLES(32'(T))
    ) u_dut (
      .i_clk   (clk),
      .i_reset (rst),
      .i_m0_cyc(m_cyc[0]),
      .i_m0_stb(m_stb[0]),
      .i_m0_wen(m_wen[0]),
      .i_m0_adr(m_adr[0]),
      .i_m0_dat(m_dat[0]),
      .i_m0_sel(m_sel[0]),
      .i_m0_cti(m_cti[0]),
      .o_m0_ack(ack0[k]),
      .o_m0_err(err0[k]),
      .i_m1_cyc(m_cyc[1]),
      .i_m1_stb(m_stb[1]),
      .i_m1_wen(m_wen[1]),
      .i_m1_adr(m_adr[1]),
      .i_m1_dat(m_dat[1]),
      .i_m1_sel(m_sel[1]),
      .i_m1_cti(m_cti[1]),
      .o_m1_ack(ack1[k]),
      .o_m1_err(err1[k]),
      .o_m_dat (mdat[k]),
      .o_wb_cyc(wcyc[k]),
      .o_wb_stb(wstb[k]),
      .o_wb_wen(wwen[k]),
      .o_wb_adr(wadr[k]),
      .o_wb_dat(wdat[k]),
      .o_wb_sel(wsel[k]),
      .o_wb_cti(wcti[k]),
      .i_wb_dat(wb_rdat),
      .i_wb_ack(wb_ack),
      .o_grant (grant[k])
    );
  end

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit tmo_fire(input int k);
    int g;
    g = owner[k];
    if (!TmoEn || g < 0) return 1'b0;
    return m_stb[g] && !wb_ack && (cnt[k] == T - 1);
  endfunction

  function automatic int pick(input int k);
    if (m_cyc[0] && m_cyc[1]) return (k == 1) ? 1 : 1 - last[k];
    if (m_cyc[0]) return 0;
    if (m_cyc[1]) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      owner[k] = -1;
      last[k]  = 1;
      cnt[k]   = 0;
    end
  endtask

  task automatic model_check();
    for (int k = 0; k < 2; k++) begin
      int          g;
      bit          fire;
      logic        e_cyc, e_stb;
      logic [31:0] e_adr, e_dat;
      logic [7:0]  e_ctl;
      logic [1:0]  e_gnt;
      g     = owner[k];
      fire  = tmo_fire(k);
      e_cyc = 1'b0;
      e_stb = 1'b0;
      e_adr = '0;
      e_dat = '0;
      e_ctl = '0;
      e_gnt = 2'b00;
      if (g >= 0) begin
        e_cyc = m_cyc[g] && !fire;
        e_stb = m_stb[g] && !fire;
        e_adr = m_adr[g];
        e_dat = m_dat[g];
        e_ctl = {m_wen[g], m_sel[g], m_cti[g]};
        e_gnt = (g == 0) ? 2'b01 : 2'b10;
      end
      chk($sformatf("mode%0d_grant", k), 32'(grant[k]), 32'(e_gnt));
      chk($sformatf("mode%0d_cyc_stb", k), {30'd0, wcyc[k], wstb[k]}, {30'd0, e_cyc, e_stb});
      chk($sformatf("mode%0d_adr", k), wadr[k], e_adr);
      chk($sformatf("mode%0d_wdat", k), wdat[k], e_dat);
      chk($sformatf("mode%0d_wen_sel_cti", k), {24'd0, wwen[k], wsel[k], wcti[k]},
          {24'd0, e_ctl});
      chk($sformatf("mode%0d_ack_err_dat", k),
          {ack1[k], ack0[k], err1[k], err0[k], mdat[k][27:0]},
          {wb_ack && g == 1, wb_ack && g == 0, fire && g == 1, fire && g == 0, wb_rdat[27:0]});
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int old;
      bit fire;
      if (rst) begin
        owner[k] = -1;
        last[k]  = 1;
        cnt[k]   = 0;
      end else begin
        fire = tmo_fire(k);
        old  = owner[k];
        if (fire) begin
          owner[k] = -1;
        end else if (owner[k] < 0 || !m_cyc[owner[k]]) begin
          owner[k] = pick(k);
          if (owner[k] >= 0) last[k] = owner[k];
        end
        if (owner[k] != old || wb_ack) cnt[k] = 0;
        else if (owner[k] >= 0 && m_stb[owner[k]]) cnt[k]++;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_masters();
    for (int j = 0; j < 2; j++) begin
      m_cyc[j] = 1'b0;
      m_stb[j] = 1'b0;
      m_wen[j] = 1'b0;
      m_adr[j] = '0;
      m_dat[j] = '0;
      m_sel[j] = '0;
      m_cti[j] = 3'b000;
    end
    wb_ack = 1'b0;
  endtask

  task automatic request(input int j, input logic [31:0] adr, input logic [2:0] cti);
    m_cyc[j] = 1'b1;
    m_stb[j] = 1'b1;
    m_adr[j] = adr;
    m_dat[j] = ~adr;
    m_sel[j] = 4'hF;
    m_cti[j] = cti;
  endtask

  initial begin
    idle_masters();
    wb_rdat = '0;
    model_reset();
    step();
    step();
    chk("reset_grant", 32'(grant[0]), 32'd0);
    chk("reset_cti", 32'(wcti[0]), 32'd0);
    rst = 1'b0;
    step();

    // Simultaneous requests: mode 0 alternates m0 then m1, mode 1 always picks m1
    for (int rep = 0; rep < 2; rep++) begin
      request(0, 32'h10, 3'b000);
      request(1, 32'h20, 3'b000);
      step();
      chk("tie_rr_first", 32'(grant[0]), 32'h1);
      chk("tie_fp_first", 32'(grant[1]), 32'h2);
      wb_ack = 1'b1;
      step();
      wb_ack = 1'b0;
      m_cyc[0] = 1'b0;
      m_stb[0] = 1'b0;
      #1;
      chk("tie_rr_gap", 32'(wcyc[0]), 32'd0);
      step();
      chk("tie_rr_second", 32'(grant[0]), 32'h2);
      m_cyc[1] = 1'b0;
      m_stb[1] = 1'b0;
      step();
      chk("tie_rr_idle", 32'(grant[0]), 32'd0);
    end

    // m0 single read, acked on the third granted cycle
    request(0, 32'h100, 3'b000);
    step();
    chk("rd_grant", 32'(grant[0]), 32'h1);
    chk("rd_adr", wadr[0], 32'h100);
    step();
    step();
    wb_ack  = 1'b1;
    wb_rdat = 32'hDEADBEEF;
    #1;
    chk("rd_m0_ack", 32'(ack0[0]), 32'd1);
    chk("rd_m1_ack", 32'(ack1[0]), 32'd0);
    chk("rd_dat", mdat[0], 32'hDEADBEEF);
    step();
    idle_masters();
    step();

    // m1 4-beat burst; m0 joins on beat 2 and must wait for m1 to drop cyc
    request(1, 32'h2000, 3'b010);
    step();
    chk("burst_grant", 32'(grant[0]), 32'h2);
    for (int b = 0; b < 4; b++) begin
      if (b == 1) request(0, 32'h300, 3'b010);
      m_adr[1] = 32'h2000 + 32'(4 * b);
      m_cti[1] = (b == 3) ? 3'b111 : 3'b010;
      wb_ack = 1'b1;
      #1;
      chk("burst_m1_ack", 32'(ack1[0]), 32'd1);
      chk("burst_m0_ack", 32'(ack0[0]), 32'd0);
      chk("burst_hold", 32'(grant[0]), 32'h2);
      step();
    end
    m_cyc[1] = 1'b0;
    m_stb[1] = 1'b0;
    wb_ack   = 1'b0;
    #1;
    chk("burst_release_cyc", 32'(wcyc[0]), 32'd0);
    step();
    chk("burst_next_grant", 32'(grant[0]), 32'h1);
    chk("burst_next_adr", wadr[0], 32'h300);

    // Asynchronous reset in the middle of the m0 burst
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("areset_cyc", 32'(wcyc[0]), 32'd0);
    chk("areset_grant", 32'(grant[0]), 32'd0);
    chk("areset_fp_grant", 32'(grant[1]), 32'd0);
    idle_masters();
    step();
    step();
    rst = 1'b0;
    step();

    // m0 strobes and is never acknowledged
    request(0, 32'h400, 3'b000);
    step();
    chk("stall_grant", 32'(grant[0]), 32'h1);
    if (TmoEn) begin
      for (int i = 1; i < T; i++) begin
        chk("stall_no_err", 32'(err0[0]), 32'd0);
        step();
      end
      chk("tmo_err", 32'(err0[0]), 32'd1);
      chk("tmo_cyc", 32'(wcyc[0]), 32'd0);
      step();
      chk("tmo_idle", 32'(grant[0]), 32'd0);
    end else begin
      for (int i = 0; i < 40; i++) begin
        chk("stall_no_err", 32'(err0[0]), 32'd0);
        chk("stall_hold", 32'(grant[0]), 32'h1);
        step();
      end
    end
    idle_masters();
    step();

    // Random traffic checked every cycle against the model
    for (int c = 0; c < 400; c++) begin
      for (int j = 0; j < 2; j++) begin
        if (m_cyc[j]) begin
          if ($urandom_range(5) == 0) m_cyc[j] = 1'b0;
        end else if ($urandom_range(3) == 0) begin
          m_cyc[j] = 1'b1;
        end
        m_stb[j] = m_cyc[j] && ($urandom_range(3) != 0);
        m_wen[j] = 1'($urandom);
        m_adr[j] = $urandom;
        m_dat[j] = $urandom;
        m_sel[j] = 4'($urandom);
        m_cti[j] = 3'($urandom);
      end
      wb_ack  = ($urandom_range(2) == 0);
      wb_rdat = $urandom;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
